sha3_lane_unloader: RTL and testbench
=====================================

Name: sha3_lane_unloader

Overview:
- Squeeze-side reader of the permutation state.
- Captures a full 1600-bit state word (the same [x][y][z] packed layout produced by the permutation step modules) in one handshake.
- Streams the first NUM_LANES lanes out, one 64-bit lane per beat, in Keccak lane order k = x + 5*y.
- Sits between the permutation round sequencer and the digest/output interface. For SHA3-256 the default emits 4 lanes (256 bits).

Parameters:
- X_AXIS, 5, lane grid x dimension.
- Y_AXIS, 5, lane grid y dimension.
- Z_AXIS, 64, lane width in bits.
- NUM_LANES, 4, lanes emitted per captured state. Legal range 1..X_AXIS*Y_AXIS; elaboration error outside it.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- st_valid  input  1  upstream state valid.
- st_ready  output  1  unloader can capture a state.
- st_data  input  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  permuted state.
- ln_valid  output  1  lane output valid.
- ln_ready  input  1  downstream accepts lane.
- ln_data  output  Z_AXIS  current lane.
- ln_last  output  1  high on the final lane beat of a state.
- ln_idx  output  $clog2(X_AXIS*Y_AXIS)  lane index k of current beat.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high. While rst=1, every flop is cleared immediately, independent of clk.
- Reset values: FSM=IDLE, st_ready=0 while rst asserted and 1 from the first clk edge after release. ln_valid=0, ln_last=0, ln_idx=0, ln_data=0, state register=0.
- FSM IDLE:
  - st_ready=1, ln_valid=0.
  - On st_valid&&st_ready at an edge: register st_data, set k=0, go to STREAM.
- FSM STREAM:
  - st_ready=0, ln_valid=1.
  - ln_data = state[k%X_AXIS][k/X_AXIS]; ln_idx=k; ln_last=(k==NUM_LANES-1).
  - On ln_valid&&ln_ready: if ln_last, go to IDLE, else k<=k+1.
  - Without ln_ready, ln_data/ln_idx/ln_last are held stable (AXI-style: valid never drops without handshake).
- Latency: first lane valid on the edge after capture. Per-state throughput is NUM_LANES beats plus 1 IDLE cycle. A capture on the same edge as the last-lane handshake is not allowed, because st_ready is registered-state decoded.
- Outputs are registered or decoded from registered state only; no combinational path from st_* or ln_ready to outputs.
- Counter width is $clog2(X_AXIS*Y_AXIS); no wrap past NUM_LANES-1.
- NUM_LANES=1: single beat with ln_last=1.
- NUM_LANES=25: k runs to 24; lane (4,4) is last.
- st_valid during STREAM is ignored (st_ready=0). Upstream must hold.
- Reset mid-STREAM: the beat is aborted; ln_valid drops asynchronously and the partial stream is never resumed.
- x/y index math uses the package mod5/div5 helpers; no `%` on run-time values in RTL.

Optional Feature:
- Macro: LANE_BYTE_SWAP_EN.
- Defined: ln_data is byte-reversed per lane (byte 0 ↔ byte 7), producing big-endian digest byte order for the output interface.
- Undefined: ln_data is the raw little-endian lane.
- No port or latency change either way.

Decomposition:
- sha3_pkg (shared):
  - lane_t (logic [63:0]) and state_t (5x5 lane_t packed [x][y][z]).
  - Constants X_AXIS/Y_AXIS/Z_AXIS/NUM_LANES_256=4.
  - Functions mod5, mod64, div5, lane_x(k), lane_y(k).
  - The same mod helpers are used by the permutation step modules.
- One sub-module: sha3_lane_mux, a combinational state_t + k → lane_t selector with optional byte swap. Reusable by the absorb-side loader.

Test Plan:
- Reset then load: state lane(x,y)=16*y+x, NUM_LANES=4, ln_ready=1 → beats 0x00,0x01,0x02,0x03 on consecutive cycles; ln_idx 0..3; ln_last only on beat 3; st_ready=1 the cycle after.
- Backpressure: same load, ln_ready low for 3 cycles at beat 1 → ln_data holds 0x01, ln_idx=1, ln_valid stays 1; resumes with 0x02.
- NUM_LANES=25 build: lane(x,y)=64'hA5A5_0000_0000_0000|(16*y+x) → 25 beats in order x+5y; beat 5 = ...0010, beat 24 = ...0044 with ln_last=1.
- Ignored input: st_valid pulsed with a different state during STREAM → outputs unchanged; new state captured only after returning to IDLE.
- Async reset mid-STREAM at beat 2, asserted between edges → ln_valid=0 immediately; after release st_ready=1, and a fresh load restarts at ln_idx=0.
- LANE_BYTE_SWAP_EN defined: lane(0,0)=64'h0011223344556677 → ln_data=64'h7766554433221100; undefined build → 64'h0011223344556677.

Source files
------------

// File: rtl/sha3_lane_unloader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_lane_unloader_pkg
//  Purpose  : Shared Keccak geometry, lane/state types and lane-index helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package sha3_lane_unloader_pkg;

    localparam int X_AXIS        = 5;
    localparam int Y_AXIS        = 5;
    localparam int Z_AXIS        = 64;
    localparam int NUM_LANES_256 = 4;

    localparam int NUM_LANE_SLOTS = X_AXIS * Y_AXIS;
    localparam int LANE_IDX_W     = $clog2(NUM_LANE_SLOTS);

    typedef logic [Z_AXIS-1:0]                    lane_t;
    typedef lane_t [X_AXIS-1:0][Y_AXIS-1:0]       state_t;
    typedef logic [LANE_IDX_W-1:0]                lane_idx_t;
    typedef logic [2:0]                           axis_idx_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } unload_state_e;

    // Threshold chain instead of a divider; valid for lane indices 0..24.
    function automatic axis_idx_t div5(input lane_idx_t v);
        if (v >= lane_idx_t'(20)) return 3'd4;
        if (v >= lane_idx_t'(15)) return 3'd3;
        if (v >= lane_idx_t'(10)) return 3'd2;
        if (v >= lane_idx_t'(5))  return 3'd1;
        return 3'd0;
    endfunction

    function automatic axis_idx_t mod5(input lane_idx_t v);
        lane_idx_t w_base;
        w_base = lane_idx_t'({2'b00, div5(v)}) * lane_idx_t'(5);
        return axis_idx_t'(v - w_base);
    endfunction

    function automatic logic [5:0] mod64(input logic [7:0] v);
        return 6'(v);
    endfunction

    function automatic axis_idx_t lane_x(input lane_idx_t k);
        return mod5(k);
    endfunction

    function automatic axis_idx_t lane_y(input lane_idx_t k);
        return div5(k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha3_lane_unloader_if.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_lane_unloader_if
//  Purpose  : State-capture and lane-stream handshake bundle of the unloader.
//  Revision : 1.0 - initial release
// ============================================================================
interface sha3_lane_unloader_if;
    import sha3_lane_unloader_pkg::*;

    logic      st_valid;
    logic      st_ready;
    state_t    st_data;
    logic      ln_valid;
    logic      ln_ready;
    lane_t     ln_data;
    logic      ln_last;
    lane_idx_t ln_idx;

    // master: upstream state producer plus downstream lane consumer
    modport master (
        output st_valid, st_data, ln_ready,
        input  st_ready, ln_valid, ln_data, ln_last, ln_idx
    );

    modport slave (
        input  st_valid, st_data, ln_ready,
        output st_ready, ln_valid, ln_data, ln_last, ln_idx
    );
endinterface
`default_nettype wire

// File: rtl/sha3_lane_unloader_mux.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_lane_mux
//  Purpose  : Selects lane k = x + 5*y from a state; LANE_BYTE_SWAP_EN
//             reverses the byte order of the selected lane.
//  Revision : 1.0 - initial release
// ============================================================================
module sha3_lane_mux
    import sha3_lane_unloader_pkg::*;
(
    input  state_t    state_i,
    input  lane_idx_t k_i,
    output lane_t     lane_o
);

    axis_idx_t w_x;
    axis_idx_t w_y;
    lane_t     w_raw;

    assign w_x   = lane_x(k_i);
    assign w_y   = lane_y(k_i);
    assign w_raw = state_i[w_x][w_y];

`ifdef LANE_BYTE_SWAP_EN
    lane_t w_swap;

    // Big-endian digest order: lane byte 0 leaves in the top byte position.
    always_comb begin
        w_swap = '0;
        for (int b = 0; b < Z_AXIS / 8; b++) begin
            w_swap[8*b +: 8] = w_raw[Z_AXIS - 8 - 8*b +: 8];
        end
    end

    assign lane_o = w_swap;
`else
    assign lane_o = w_raw;
`endif

endmodule
`default_nettype wire

// File: rtl/sha3_lane_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_lane_unloader
//  Purpose  : Captures a permuted 1600-bit state and streams its first
//             NUM_LANES lanes, one per beat, in Keccak order k = x + 5*y.
//             Optional macro LANE_BYTE_SWAP_EN byte-reverses each lane.
//  Revision : 1.0 - initial release
// ============================================================================
module sha3_lane_unloader #(
    parameter int X_AXIS    = sha3_lane_unloader_pkg::X_AXIS,
    parameter int Y_AXIS    = sha3_lane_unloader_pkg::Y_AXIS,
    parameter int Z_AXIS    = sha3_lane_unloader_pkg::Z_AXIS,
    parameter int NUM_LANES = sha3_lane_unloader_pkg::NUM_LANES_256
) (
    input  wire                   clk,
    input  wire                   rst,
    sha3_lane_unloader_if.slave   bus
);
    import sha3_lane_unloader_pkg::*;

    if ((NUM_LANES < 1) || (NUM_LANES > X_AXIS * Y_AXIS)) begin : g_bad_num_lanes
        $error("sha3_lane_unloader: NUM_LANES must be within 1..X_AXIS*Y_AXIS");
    end

    if ((X_AXIS != sha3_lane_unloader_pkg::X_AXIS) ||
        (Y_AXIS != sha3_lane_unloader_pkg::Y_AXIS) ||
        (Z_AXIS != sha3_lane_unloader_pkg::Z_AXIS)) begin : g_bad_geometry
        $error("sha3_lane_unloader: lane grid must match the Keccak-f[1600] package geometry");
    end

    localparam lane_idx_t LAST_K = lane_idx_t'(NUM_LANES - 1);

    unload_state_e fsm_q;
    logic          st_ready_q;
    logic          ln_valid_q;
    logic          ln_last_q;
    lane_idx_t     k_q;
    lane_idx_t     k_d;
    state_t        state_q;
    lane_t         w_lane;

    assign k_d = k_q + lane_idx_t'(1);

    // st_ready is a flop rather than an IDLE decode so it stays low during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= ST_IDLE;
            st_ready_q <= 1'b0;
            ln_valid_q <= 1'b0;
            ln_last_q  <= 1'b0;
            k_q        <= '0;
            state_q    <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    st_ready_q <= 1'b1;
                    if (bus.st_valid && st_ready_q) begin
                        state_q    <= bus.st_data;
                        k_q        <= '0;
                        ln_valid_q <= 1'b1;
                        ln_last_q  <= (NUM_LANES == 1);
                        st_ready_q <= 1'b0;
                        fsm_q      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (ln_valid_q && bus.ln_ready) begin
                        if (ln_last_q) begin
                            fsm_q      <= ST_IDLE;
                            st_ready_q <= 1'b1;
                            ln_valid_q <= 1'b0;
                            ln_last_q  <= 1'b0;
                            k_q        <= '0;
                        end else begin
                            k_q       <= k_d;
                            ln_last_q <= (k_d == LAST_K);
                        end
                    end
                end
                default: begin
                    fsm_q      <= ST_IDLE;
                    st_ready_q <= 1'b0;
                    ln_valid_q <= 1'b0;
                    ln_last_q  <= 1'b0;
                    k_q        <= '0;
                end
            endcase
        end
    end

    sha3_lane_mux u_lane_mux (
        .state_i (state_q),
        .k_i     (k_q),
        .lane_o  (w_lane)
    );

    assign bus.st_ready = st_ready_q;
    assign bus.ln_valid = ln_valid_q;
    assign bus.ln_last  = ln_last_q;
    assign bus.ln_idx   = k_q;
    assign bus.ln_data  = w_lane;

endmodule
`default_nettype wire

// File: tb/tb_sha3_lane_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha3_lane_unloader
//  Purpose  : Self-checking bench for 4-, 25- and 1-lane unloader builds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha3_lane_unloader;
    import sha3_lane_unloader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sha3_lane_unloader_if if4 ();
    sha3_lane_unloader_if if25 ();
    sha3_lane_unloader_if if1 ();

    sha3_lane_unloader #(.NUM_LANES(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    sha3_lane_unloader #(.NUM_LANES(25)) u_dut25 (.clk(clk), .rst(rst), .bus(if25));
    sha3_lane_unloader #(.NUM_LANES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));

    typedef struct packed {
        logic      st_ready;
        logic      ln_valid;
        logic      ln_last;
        lane_idx_t ln_idx;
        lane_t     ln_data;
    } obs_t;

    typedef struct {
        int    sel;
        int    nl;
        lane_t base;
        int    k;
        lane_t exp_raw;
        logic  exp_last;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic obs_t obs(input int sel);
        obs_t o;
        case (sel)
            0:       o = {if4.st_ready,  if4.ln_valid,  if4.ln_last,  if4.ln_idx,  if4.ln_data};
            1:       o = {if25.st_ready, if25.ln_valid, if25.ln_last, if25.ln_idx, if25.ln_data};
            default: o = {if1.st_ready,  if1.ln_valid,  if1.ln_last,  if1.ln_idx,  if1.ln_data};
        endcase
        return o;
    endfunction

    task automatic drive_st(input int sel, input logic v, input state_t d);
        case (sel)
            0:       begin if4.st_valid  = v; if4.st_data  = d; end
            1:       begin if25.st_valid = v; if25.st_data = d; end
            default: begin if1.st_valid  = v; if1.st_data  = d; end
        endcase
    endtask

    task automatic drive_rdy(input int sel, input logic r);
        case (sel)
            0:       if4.ln_ready  = r;
            1:       if25.ln_ready = r;
            default: if1.ln_ready  = r;
        endcase
    endtask

    function automatic lane_t disp(input lane_t l);
        lane_t r;
`ifdef LANE_BYTE_SWAP_EN
        r = {<<8{l}};
`else
        r = l;
`endif
        return r;
    endfunction

    function automatic lane_t exp_lane(input state_t s, input int k);
        return disp(s[k % X_AXIS][k / X_AXIS]);
    endfunction

    function automatic state_t pat(input lane_t base);
        state_t s;
        for (int x = 0; x < X_AXIS; x++)
            for (int y = 0; y < Y_AXIS; y++)
                s[x][y] = base | lane_t'(16 * y + x);
        return s;
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int x = 0; x < X_AXIS; x++)
            for (int y = 0; y < Y_AXIS; y++)
                s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic check_beat(input string name, input int sel, input state_t s, input int k, input int nl);
        obs_t o;
        o = obs(sel);
        check($sformatf("%s_k%0d", name, k), {o.ln_valid, o.ln_last, o.ln_idx, o.ln_data},
              {1'b1, (k == nl - 1), lane_idx_t'(k), exp_lane(s, k)});
    endtask

    task automatic check_idle(input string name, input int sel);
        obs_t o;
        o = obs(sel);
        check(name, {o.st_ready, o.ln_valid, o.ln_last}, 3'b100);
    endtask

    // Presents s and returns #1 after the capturing edge.
    task automatic load(input int sel, input state_t s);
        obs_t o;
        int   n;
        drive_st(sel, 1'b1, s);
        n = 0;
        do begin
            @(negedge clk);
            o = obs(sel);
            n++;
        end while (!o.st_ready && n < 50);
        if (!o.st_ready) check("load_timeout", 0, 1);
        @(posedge clk);
        #1;
        drive_st(sel, 1'b0, s);
    endtask

    task automatic stream(input string name, input int sel, input state_t s, input int nl);
        for (int k = 0; k < nl; k++) begin
            @(negedge clk);
            check_beat(name, sel, s, k, nl);
        end
        @(negedge clk);
        check_idle({name, "_idle"}, sel);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        state_t s, s2, sa, sb;
        obs_t   o;
        int     k, n;

        vt[0] = '{0, 4,  64'h0,                   0,  64'h00,                  1'b0};
        vt[1] = '{0, 4,  64'h0,                   1,  64'h01,                  1'b0};
        vt[2] = '{0, 4,  64'h0,                   2,  64'h02,                  1'b0};
        vt[3] = '{0, 4,  64'h0,                   3,  64'h03,                  1'b1};
        vt[4] = '{1, 25, 64'hA5A5_0000_0000_0000, 5,  64'hA5A5_0000_0000_0010, 1'b0};
        vt[5] = '{1, 25, 64'hA5A5_0000_0000_0000, 24, 64'hA5A5_0000_0000_0044, 1'b1};
        vt[6] = '{1, 25, 64'hA5A5_0000_0000_0000, 12, 64'hA5A5_0000_0000_0022, 1'b0};
        vt[7] = '{2, 1,  64'hDEAD_0000_0000_0000, 0,  64'hDEAD_0000_0000_0000, 1'b1};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_st(i, 1'b0, '0);
            drive_rdy(i, 1'b0);
        end

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            check($sformatf("reset_state_dut%0d", i), o, '0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("st_ready_after_release", obs(0).st_ready, 1'b1);
        for (int i = 0; i < 3; i++) drive_rdy(i, 1'b1);

        // Directed vector table: full stream per row, plus the row's pinned beat.
        for (int i = 0; i < 8; i++) begin
            s = pat(vt[i].base);
            load(vt[i].sel, s);
            for (int b = 0; b < vt[i].nl; b++) begin
                @(negedge clk);
                check_beat($sformatf("vec%0d", i), vt[i].sel, s, b, vt[i].nl);
                if (b == vt[i].k) begin
                    o = obs(vt[i].sel);
                    check($sformatf("vec%0d_pinned", i), {o.ln_last, o.ln_data},
                          {vt[i].exp_last, disp(vt[i].exp_raw)});
                end
            end
            @(negedge clk);
            check_idle($sformatf("vec%0d_idle", i), vt[i].sel);
        end

        // Backpressure: hold beat 1 for three cycles.
        s = pat(64'h0);
        load(0, s);
        @(negedge clk);
        check_beat("bp", 0, s, 0, 4);
        @(posedge clk);
        #1;
        drive_rdy(0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_beat("bp_hold", 0, s, 1, 4);
        end
        @(posedge clk);
        #1;
        drive_rdy(0, 1'b1);
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            check_beat("bp_resume", 0, s, b, 4);
        end
        @(negedge clk);
        check_idle("bp_idle", 0);

        // st_valid during STREAM must be ignored until IDLE.
        sa = pat(64'h1111_0000_0000_0000);
        sb = pat(64'h2222_0000_0000_0000);
        load(0, sa);
        drive_st(0, 1'b1, sb);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check_beat("ign_a", 0, sa, b, 4);
            check($sformatf("ign_st_ready_k%0d", b), obs(0).st_ready, 1'b0);
        end
        @(negedge clk);
        check_idle("ign_gap", 0);
        @(posedge clk);
        #1;
        drive_st(0, 1'b0, sb);
        stream("ign_b", 0, sb, 4);

        // Byte order of lane (0,0).
        s = '0;
        s[0][0] = 64'h0011_2233_4455_6677;
        load(0, s);
        @(negedge clk);
`ifdef LANE_BYTE_SWAP_EN
        check("byte_order_lane00", obs(0).ln_data, 64'h7766_5544_3322_1100);
`else
        check("byte_order_lane00", obs(0).ln_data, 64'h0011_2233_4455_6677);
`endif
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            check_beat("byte_order", 0, s, b, 4);
        end
        @(negedge clk);
        check_idle("byte_order_idle", 0);

        // Asynchronous reset between edges while beat 2 is on the bus.
        s = pat(64'h3333_0000_0000_0000);
        load(0, s);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check_beat("arst_pre", 0, s, b, 4);
        end
        #2;
        rst = 1'b1;
        #1;
        o = obs(0);
        check("arst_drop", {o.st_ready, o.ln_valid, o.ln_last, o.ln_idx}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("arst_release", 0);
        s2 = pat(64'h4444_0000_0000_0000);
        load(0, s2);
        stream("arst_fresh", 0, s2, 4);

        // Randomised states with random downstream backpressure.
        for (int t = 0; t < 30; t++) begin
            s = rand_state();
            load(0, s);
            k = 0;
            n = 0;
            while (k < 4 && n < 200) begin
                drive_rdy(0, 1'($urandom_range(0, 1)));
                @(negedge clk);
                check_beat($sformatf("rnd%0d", t), 0, s, k, 4);
                if (if4.ln_ready) k++;
                n++;
                @(posedge clk);
                #1;
            end
            if (k < 4) check($sformatf("rnd%0d_timeout", t), k, 4);
            drive_rdy(0, 1'b1);
            @(negedge clk);
            check_idle($sformatf("rnd%0d_idle", t), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
